// File: rtl/z80_bus_pkg.sv
// Shared definitions for the Z80 bus responder.
// FSM encoding and address-space selectors.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    ST_ARM,
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_SKIP
  } state_e;

  localparam bit SPACE_IO  = 1'b0;
  localparam bit SPACE_MEM = 1'b1;

  function automatic logic addr_hit(
    input logic [15:0] addr,
    input logic [15:0] base,
    input logic [15:0] mask
  );
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/z80_sync2.sv
// Two-flop synchroniser for active-low strobes.
// Both stages reset to 1 (the idle level of the bus).
module z80_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign dout = s2;

endmodule

// File: rtl/z80_io_slave.sv
// Z80 bus responder: decodes an address window and turns
// bus cycles into clk-domain register strobes.
module z80_io_slave
  import z80_bus_pkg::*;
#(
  parameter bit          SPACE  = SPACE_IO,
  parameter logic [15:0] BASE   = 16'h00E0,
  parameter logic [15:0] MASK   = 16'h00F0,
  parameter int          REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mreq_n,
  input  logic              iorq_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic [15:0]       a,
  inout  wire  [7:0]        d,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              rd_stb
);

  logic sel_raw;
  logic drive;

  assign sel_raw = (SPACE ? ~mreq_n : ~iorq_n)
                 & addr_hit(a, BASE, MASK);
  assign drive   = sel_raw & ~rd_n & wr_n;
  assign d       = drive ? rd_data : 8'hzz;
  assign rd_addr = a[REG_AW-1:0];

  logic [3:0] strb_s;
  logic       mreq_s2;
  logic       iorq_s2;
  logic       rd_s2;
  logic       wr_s2;

  z80_sync2 #(
    .W (4)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({mreq_n, iorq_n, rd_n, wr_n}),
    .dout  (strb_s)
  );

  assign {mreq_s2, iorq_s2, rd_s2, wr_s2} = strb_s;

  logic [15:0] a_q;
  logic [7:0]  d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a;
      d_q <= d;
    end
  end

  logic act_s;
  logic sel_s;
  logic idle_s;

  assign act_s  = SPACE ? ~mreq_s2 : ~iorq_s2;
  assign sel_s  = addr_hit(a_q, BASE, MASK);
  assign idle_s = &strb_s;

  // Synchroniser flops reset to 1, so right after release they
  // still show idle; wait until real pin samples have arrived.
  logic [1:0] flush_cnt;
  logic       flushed;

  assign flushed = flush_cnt == 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt <= '0;
    end else if (!flushed) begin
      flush_cnt <= flush_cnt + 2'd1;
    end
  end

  logic go_wr;
  logic go_rd;
  logic go_skip;
  logic done_s;

  assign go_wr   = act_s & ~wr_s2 & rd_s2 & sel_s;
  assign go_rd   = act_s & ~rd_s2 & wr_s2 & sel_s;
  assign go_skip = act_s & (~sel_s | (~rd_s2 & ~wr_s2));
  assign done_s  = ~act_s | (rd_s2 & wr_s2);

  state_e state;
  state_e state_nx;
  logic   wr_fire;
  logic   rd_fire;

  always_comb begin
    state_nx = state;
    wr_fire  = 1'b0;
    rd_fire  = 1'b0;
    unique case (state)
      ST_ARM: begin
        if (flushed && idle_s) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        unique case (1'b1)
          go_wr: begin
            state_nx = ST_WR;
            wr_fire  = 1'b1;
          end
          go_rd: begin
            state_nx = ST_RD;
            rd_fire  = 1'b1;
          end
          go_skip: state_nx = ST_SKIP;
          default: state_nx = ST_IDLE;
        endcase
      end
      ST_WR, ST_RD, ST_SKIP: begin
        if (done_s) state_nx = ST_IDLE;
      end
      default: state_nx = ST_ARM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_ARM;
      wr_stb  <= 1'b0;
      rd_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state  <= state_nx;
      wr_stb <= wr_fire;
      rd_stb <= rd_fire;
      if (wr_fire) begin
        wr_addr <= a_q[REG_AW-1:0];
        wr_data <= d_q;
      end
    end
  end

endmodule

// File: tb/tb_z80_io_slave.sv
// Scoreboard bench for z80_io_slave: Z80 cycle tasks push
// expected strobes, a negedge monitor pops and compares.
module tb_z80_io_slave;
  import z80_bus_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mreq_n = 1'b1;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [15:0] a = 16'h0000;
  wire  [7:0]  d;
  logic        wr_stb;
  logic [3:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [3:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        rd_stb;

  logic        tb_oe = 1'b0;
  logic [7:0]  tb_dq = 8'h00;

  assign d = tb_oe ? tb_dq : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (d[i]);
  end

  assign rd_data = (rd_addr == 4'd3) ? 8'hA5 : {4'hC, rd_addr};

  z80_io_slave #(
    .SPACE  (SPACE_IO),
    .BASE   (16'h00E0),
    .MASK   (16'h00F0),
    .REG_AW (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mreq_n  (mreq_n),
    .iorq_n  (iorq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .a       (a),
    .d       (d),
    .wr_stb  (wr_stb),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .rd_stb  (rd_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_wr;
    logic [3:0] addr;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (wr_stb || rd_stb) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: wr_stb=%0b rd_stb=%0b want none",
                 wr_stb, rd_stb);
      end else begin
        e = q.pop_front();
        chk("strobe_kind", {30'd0, wr_stb, rd_stb},
            e.is_wr ? 32'd2 : 32'd1);
        chk("strobe_cycle", cyc, e.at);
        if (e.is_wr) begin
          chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end else begin
          chk("rd_addr", {28'd0, rd_addr}, {28'd0, e.addr});
        end
      end
    end
  end

  task automatic buswr(input logic [15:0] addr, input logic [7:0] data,
                       input bit mem, input bit hit);
    @(negedge clk);
    a = addr;
    tb_dq = data;
    tb_oe = 1'b1;
    @(negedge clk);
    if (mem) mreq_n = 1'b0;
    else iorq_n = 1'b0;
    wr_n = 1'b0;
    if (hit) q.push_back('{is_wr: 1'b1, addr: addr[3:0],
                          data: data, at: cyc + 3});
    repeat (4) @(negedge clk);
    mreq_n = 1'b1;
    iorq_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic iord(input logic [15:0] addr, input bit hit,
                      output logic [7:0] data);
    @(negedge clk);
    a = addr;
    @(negedge clk);
    chk("d_z_before_rd", {24'd0, d}, 32'hFF);
    iorq_n = 1'b0;
    rd_n = 1'b0;
    if (hit) q.push_back('{is_wr: 1'b0, addr: addr[3:0],
                          data: 8'h00, at: cyc + 3});
    repeat (3) @(negedge clk);
    data = d;
    @(negedge clk);
    iorq_n = 1'b1;
    rd_n = 1'b1;
    @(negedge clk);
    chk("d_z_after_rd", {24'd0, d}, 32'hFF);
    repeat (2) @(negedge clk);
  endtask

  logic [7:0] r;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("rst_rd_stb", {31'd0, rd_stb}, 32'd0);
    chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_d_z", {24'd0, d}, 32'hFF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    buswr(16'h00EF, 8'h5A, 1'b0, 1'b1);
    chk("wr_data_hold", {24'd0, wr_data}, 32'h5A);

    iord(16'h00E3, 1'b1, r);
    chk("iord_data", {24'd0, r}, 32'hA5);

    buswr(16'h00DF, 8'h11, 1'b0, 1'b0);
    buswr(16'h00E1, 8'h22, 1'b1, 1'b0);
    chk("miss_wr_data", {24'd0, wr_data}, 32'h5A);
    iord(16'h00D0, 1'b0, r);
    chk("miss_rd_z", {24'd0, r}, 32'hFF);

    buswr(16'h00E1, 8'h01, 1'b0, 1'b1);
    buswr(16'h00E2, 8'h02, 1'b0, 1'b1);

    @(negedge clk);
    a = 16'h00E4;
    tb_dq = 8'h33;
    tb_oe = 1'b1;
    @(negedge clk);
    iorq_n = 1'b0;
    wr_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_wr_stb", {31'd0, wr_stb}, 32'd0);
    chk("midrst_state", 32'(dut.state), 32'(ST_ARM));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    iorq_n = 1'b1;
    wr_n = 1'b1;
    @(negedge clk);
    tb_oe = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_wr_data", {24'd0, wr_data}, 32'd0);
    buswr(16'h00E4, 8'h44, 1'b0, 1'b1);
    chk("post_rst_wr_data", {24'd0, wr_data}, 32'h44);

    @(negedge clk);
    a = 16'h00E0;
    @(negedge clk);
    iorq_n = 1'b0;
    rd_n = 1'b0;
    wr_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("illegal_d_z", {24'd0, d}, 32'hFF);
    chk("illegal_state", 32'(dut.state), 32'(ST_SKIP));
    iorq_n = 1'b1;
    rd_n = 1'b1;
    wr_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("illegal_idle", 32'(dut.state), 32'(ST_IDLE));

    repeat (5) @(negedge clk);
    chk("queue_empty", q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
